// File: rtl/mac32_bitserial_ctrl_if.sv
// Job / result / MAC-side signal bundle for the bit-serial MAC32 sequencer.
// master: surrounding system (activation buffer, result writer, MAC array).
// slave : the sequencer itself.
interface mac32_bitserial_ctrl_if #(
  parameter int ABITS = 4
);
  localparam int ACCW = 8 + ABITS;

  logic                  in_valid;
  logic                  in_ready;
  logic [32*ABITS-1:0]   in_act;
  logic [31:0]           mac_in;
  logic                  mac_clr;
  logic [7:0]            mac_out;
  logic                  res_valid;
  logic                  res_ready;
  logic [ACCW-1:0]       res_data;

  modport master (
    output in_valid, in_act, res_ready, mac_out,
    input  in_ready, mac_in, mac_clr, res_valid, res_data
  );

  modport slave (
    input  in_valid, in_act, res_ready, mac_out,
    output in_ready, mac_in, mac_clr, res_valid, res_data
  );
endinterface

// File: rtl/mac32_bitserial_ctrl.sv
// Bit-serial activation sequencer for the 32-lane 3b-weight x 1b-input MAC.
// Issues one activation bit-plane per cycle (MSB first) and shift-accumulates
// the MAC's registered partial sums into an unsigned ACCW-bit dot product.
module mac32_bitserial_ctrl #(
  parameter int ABITS = 4
) (
  input logic                   CLK,
  input logic                   reset,
  mac32_bitserial_ctrl_if.slave bus
);
  localparam int ACCW = 8 + ABITS;
  localparam int CW   = (ABITS > 1) ? $clog2(ABITS) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CW-1:0]       bitcnt;
  logic                acc_en;
  logic [ACCW-1:0]     acc;
  logic [32*ABITS-1:0] act_q;
  logic [31:0]         plane;
  logic [ABITS-1:0]    lane;

  // State register
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; in_valid only matters in IDLE, res_ready only in DONE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = ISSUE;
      ISSUE:   if (bitcnt == '0)  state_nxt = DRAIN;
      DRAIN:                      state_nxt = DONE;
      DONE:    if (bus.res_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Job datapath: latch activations, walk the bit counter, shift-accumulate.
  // acc_en lags ISSUE by one cycle to line up with the MAC's output register.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      act_q  <= '0;
      acc    <= '0;
      acc_en <= 1'b0;
      bitcnt <= '0;
    end else begin
      acc_en <= (state == ISSUE);
      if (state == IDLE && bus.in_valid) begin
        act_q  <= bus.in_act;
        acc    <= '0;
        bitcnt <= CW'(ABITS - 1);
      end else begin
        if (state == ISSUE && bitcnt != '0) bitcnt <= bitcnt - CW'(1);
        if (acc_en) acc <= (acc << 1) + ACCW'(bus.mac_out);
      end
    end
  end

  // Bit-plane select: bit bitcnt of every lane's activation
  always_comb begin
    plane = '0;
    lane  = '0;
    for (int i = 0; i < 32; i++) begin
      lane     = act_q[i*ABITS +: ABITS] >> bitcnt;
      plane[i] = lane[0];
    end
  end

  // Outputs, decoded from registered state only
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.res_valid = (state == DONE);
    bus.mac_clr   = (state == IDLE) || (state == DONE);
    bus.mac_in    = (state == ISSUE) ? plane : 32'd0;
    bus.res_data  = acc;
  end
endmodule

// File: doc/mac32_bitserial_ctrl.md
# mac32_bitserial_ctrl

Bit-serial activation sequencer for the 32-lane 3-bit-weight × 1-bit-input MAC (`MAC32_3bx1b`). It accepts 32 unsigned ABITS-bit activations per job and issues them to the MAC one bit-plane per cycle, MSB first. It shift-accumulates the MAC's registered 8-bit partial sums into a full-precision dot product and returns the result over a valid/ready handshake. It sits between the activation buffer and the result writer; weights are driven to the MAC directly by the weight register file.

## Interface
Parameters:
- ABITS, 4, activation width in bits (legal 1..8)
- ACCW, 8+ABITS, result width; fixed by derivation, never overridden

Ports:
- CLK  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  activation job valid
- in_ready  out  1  controller can accept a job
- in_act  in  32*ABITS  activation i in bits [i*ABITS +: ABITS], i = 0..31, unsigned
- mac_in  out  32  bit-plane to MAC `in`; bit i feeds lane i (weight i+1)
- mac_clr  out  1  drives MAC synchronous active-high `reset`
- mac_out  in  8  MAC registered partial sum
- res_valid  out  1  result valid
- res_ready  in  1  downstream accepts result
- res_data  out  ACCW  unsigned dot product Σ act_i·w_i

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - in_ready=1, mac_in=0, mac_clr=1.
  - On in_valid: latch in_act into the activation register, set acc=0, bitcnt=ABITS-1, and go to ISSUE.
- ISSUE:
  - mac_in[i] = act_i[bitcnt]; mac_clr=0.
  - Each cycle: if bitcnt==0 go to DRAIN, else bitcnt-=1.
- Accumulate enable:
  - acc_en is a register set in every cycle the FSM is in ISSUE. It is therefore high one cycle after each issued plane.
  - When acc_en=1: acc <= (acc<<1) + mac_out, zero-extended to ACCW.
- DRAIN:
  - mac_in=0, mac_clr=0.
  - Accumulates the final plane via acc_en, then goes to DONE.
- DONE:
  - res_valid=1 and res_data=acc, held stable until res_ready.
  - mac_clr=1, in_ready=0.
  - On res_ready go to IDLE.
- Width rule: per-plane sum ≤ 32·7 = 224 fits 8 bits. Final result ≤ 224·(2^ABITS−1) < 2^ACCW, so there is no overflow and no saturation logic.
- Weight inputs must be stable from the accepting edge until res_valid. The controller does not check this.
- in_valid outside IDLE is ignored; no job is queued.
- res_ready outside DONE is ignored.
- ABITS=1: ISSUE lasts exactly one cycle; the FSM still passes through DRAIN.

## Timing
- Reset (async assert, any state): state=IDLE, acc=0, acc_en=0, bitcnt=0, activation register=0.
  - Output values during reset: in_ready=1, res_valid=0, res_data=0, mac_in=0, mac_clr=1.
  - Deassertion is synchronised externally.
- Reset mid-job aborts the job: no result is produced, and the next job starts clean.
- Cycle numbering, with accept on the edge ending cycle 0:
  - ISSUE occupies cycles 1..ABITS; plane ABITS-1−(k−1) is on mac_in in cycle k.
  - mac_out for the plane issued in cycle k is valid in cycle k+1 and is accumulated at the end of cycle k+1.
  - DRAIN is cycle ABITS+1.
  - res_valid rises in cycle ABITS+2.
- Job latency is accept-edge to res_valid = ABITS+2 cycles. Minimum job period with res_ready tied high is ABITS+3 cycles.
- in_ready and res_valid are decoded from registered state only; there are no combinational paths from in_valid or res_ready to any output.
- Simultaneous res_ready and in_valid in DONE: only the result is retired, and the new job is accepted no earlier than the following IDLE cycle.

## Test plan
- ABITS=4; all weights 7, all activations 15 → res_data=3360 in cycle 6 after accept. mac_in=0xFFFFFFFF for cycles 1–4.
- Only act_0=10 (4'b1010) with weight1=3; all other activations 0 → mac_in sequence 1,0,1,0 in cycles 1–4; res_data=30.
- Random weights and activations, 200 jobs, with res_ready randomly stalled → each res_data equals the reference Σ act_i·w_i. res_data is stable while res_valid=1 and res_ready=0, and in_ready stays 0.
- Assert reset low in cycle 2 of ISSUE → outputs take their reset values immediately. The next job (all activations 1, all weights 1) returns 32.
- in_valid held high throughout a job with changing in_act → only the value present at the accepting edge is used. No second accept occurs before IDLE.
- Build with ABITS=1: act_5=1, weight6=5, all else 0 → res_data=5 three cycles after accept.
